// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Frame storage for the instruction cache: combinational read, synchronous write,
// valid bits cleared asynchronously on nRST (tag/data left uninitialised).
module icache_array
  import icache_pkg::*;
#(
  parameter  int SETS  = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wIdx,
  input  logic [TAG_W-1:0] i_wTag,
  input  logic [31:0]      i_wData,
  input  logic [IDX_W-1:0] i_rIdx,
  output logic             o_rValid,
  output logic [TAG_W-1:0] o_rTag,
  output logic [31:0]      o_rData
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wIdx] <= 1'b1;
    end
  end

  // A valid bit of zero hides whatever tag/data remain, so these need no reset.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_tag[i_wIdx]  <= i_wTag;
      r_data[i_wIdx] <= i_wData;
    end
  end

  assign o_rValid = r_valid[i_rIdx];
  assign o_rTag   = r_tag[i_rIdx];
  assign o_rData  = r_data[i_rIdx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, blocking, read-only instruction cache with a 0-cycle hit path.
// Define ICACHE_PERF_EN to add saturating hit_count / miss_count outputs.
module icache
  import icache_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t r_state;
  logic [31:0]   r_missAddr;

  logic [IDX_W-1:0] w_reqIdx;
  logic [TAG_W-1:0] w_reqTag;
  logic [IDX_W-1:0] w_missIdx;
  logic [TAG_W-1:0] w_missTag;
  logic             w_rdValid;
  logic [TAG_W-1:0] w_rdTag;
  logic [31:0]      w_rdData;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;

  assign w_reqIdx  = imemaddr[IDX_W+1:2];
  assign w_reqTag  = imemaddr[31:IDX_W+2];
  assign w_missIdx = r_missAddr[IDX_W+1:2];
  assign w_missTag = r_missAddr[31:IDX_W+2];

  icache_array #(
    .SETS (SETS)
  ) u_array (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_we     (w_fill),
    .i_wIdx   (w_missIdx),
    .i_wTag   (w_missTag),
    .i_wData  (iload),
    .i_rIdx   (w_reqIdx),
    .o_rValid (w_rdValid),
    .o_rTag   (w_rdTag),
    .o_rData  (w_rdData)
  );

  // Lookups are only honoured in IDLE; during a fill the request address is ignored.
  assign w_hit  = (r_state == IDLE) && imemREN && w_rdValid && (w_rdTag == w_reqTag);
  assign w_miss = (r_state == IDLE) && imemREN && !w_hit;
  assign w_fill = (r_state == FETCH) && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_missAddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_missAddr <= wordAlign(imemaddr);
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ihit     = w_hit;
  assign imemload = w_hit ? w_rdData : 32'h0;
  assign iREN     = (r_state == FETCH);
  assign iaddr    = r_missAddr;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (w_hit) begin
        r_hitCount <= satInc(r_hitCount);
      end
      if (w_miss) begin
        r_missCount <= satInc(r_missCount);
      end
    end
  end

  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic
// against a word-address level cache model; also covers ICACHE_PERF_EN builds.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  int total = 0;
  int bad   = 0;

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hitCount),
    .miss_count (missCount)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Memory responder: latFixed >= 0 pins the number of busy cycles, otherwise random.
  int latFixed = 2;
  bit memActive = 1'b0;
  int memLeft = 0;

  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      if (!memActive) begin
        memActive = 1'b1;
        memLeft   = (latFixed >= 0) ? latFixed : int'($urandom_range(0, 4));
      end else if (memLeft > 0) begin
        memLeft--;
      end
      iwait = (memLeft != 0);
      iload = iwait ? $urandom : memWord(iaddr);
    end else begin
      memActive = 1'b0;
      iwait     = $urandom_range(0, 1) == 1;
      iload     = $urandom;
    end
  end

  // Reference model: which word address each slot holds, plus any pending miss.
  bit          mHas  [16];
  logic [31:0] mAddr [16];
  bit          mBusy = 1'b0;
  logic [31:0] mMiss = 32'h0;
  int          mHits = 0;
  int          mMisses = 0;

  always @(negedge CLK) begin
    logic [31:0] wa;
    int          idx;
    bit          expHit;
    if (!nRST) begin
      checkOutput("rst ihit", {31'h0, ihit}, 32'h0);
      checkOutput("rst imemload", imemload, 32'h0);
      checkOutput("rst iREN", {31'h0, iREN}, 32'h0);
      checkOutput("rst iaddr", iaddr, 32'h0);
      for (int i = 0; i < 16; i++) mHas[i] = 1'b0;
      mBusy   = 1'b0;
      mMiss   = 32'h0;
      mHits   = 0;
      mMisses = 0;
    end else begin
      wa     = {imemaddr[31:2], 2'b00};
      idx    = int'(imemaddr[5:2]);
      expHit = !mBusy && imemREN && mHas[idx] && (mAddr[idx] == wa);
      checkOutput("model ihit", {31'h0, ihit}, {31'h0, expHit});
      checkOutput("model imemload", imemload, expHit ? memWord(wa) : 32'h0);
      checkOutput("model iREN", {31'h0, iREN}, {31'h0, mBusy});
      checkOutput("model iaddr", iaddr, mMiss);
`ifdef ICACHE_PERF_EN
      checkOutput("model hit_count", hitCount, mHits);
      checkOutput("model miss_count", missCount, mMisses);
`endif
      if (mBusy) begin
        if (!iwait) begin
          mHas[int'(mMiss[5:2])]  = 1'b1;
          mAddr[int'(mMiss[5:2])] = mMiss;
          mBusy = 1'b0;
        end
      end else if (imemREN && !expHit) begin
        mMiss = wa;
        mBusy = 1'b1;
        mMisses++;
      end
      if (expHit) mHits++;
    end
  end

  task automatic applyStimulus(input logic ren, input logic [31:0] addr);
    @(posedge CLK);
    #1;
    imemREN  = ren;
    imemaddr = addr;
  endtask

  task automatic peek();
    @(negedge CLK);
    #1;
  endtask

  // Miss cycle, lat+1 fetch cycles, then the hit with unchanged address.
  task automatic missAndFill(input logic [31:0] addr, input int lat,
                             input logic [31:0] expData);
    latFixed = lat;
    applyStimulus(1'b1, addr);
    peek();
    checkOutput("miss ihit", {31'h0, ihit}, 32'h0);
    checkOutput("miss iREN", {31'h0, iREN}, 32'h0);
    for (int k = 0; k <= lat; k++) begin
      applyStimulus(1'b1, addr);
      peek();
      checkOutput("fetch iREN", {31'h0, iREN}, 32'h1);
      checkOutput("fetch iaddr", iaddr, {addr[31:2], 2'b00});
      checkOutput("fetch ihit", {31'h0, ihit}, 32'h0);
    end
    applyStimulus(1'b1, addr);
    peek();
    checkOutput("fill hit", {31'h0, ihit}, 32'h1);
    checkOutput("fill data", imemload, expData);
    checkOutput("fill iREN", {31'h0, iREN}, 32'h0);
  endtask

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit done;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    repeat (3) @(posedge CLK);
    peek();
    checkOutput("reset iREN", {31'h0, iREN}, 32'h0);
    checkOutput("reset iaddr", iaddr, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss, then re-request hits in the same cycle.
    missAndFill(32'h0000_0040, 2, 32'h2001_0005);
    applyStimulus(1'b1, 32'h0000_0043);
    peek();
    checkOutput("rehit ihit", {31'h0, ihit}, 32'h1);
    checkOutput("rehit iREN", {31'h0, iREN}, 32'h0);
    checkOutput("rehit data", imemload, 32'h2001_0005);
    applyStimulus(1'b0, 32'h0000_0040);
    peek();
`ifdef ICACHE_PERF_EN
    checkOutput("perf hit_count", hitCount, 32'd2);
    checkOutput("perf miss_count", missCount, 32'd1);
`endif

    // Conflict on index 0 evicts 0x40.
    missAndFill(32'h0000_0080, 1, memWord(32'h0000_0080));
    missAndFill(32'h0000_0040, 0, 32'h2001_0005);

    // Request dropped and address changed mid-fetch; fill still lands.
    latFixed = 3;
    applyStimulus(1'b1, 32'h0000_0104);
    peek();
    checkOutput("drop miss ihit", {31'h0, ihit}, 32'h0);
    applyStimulus(1'b0, 32'h0000_0200);
    peek();
    checkOutput("drop iREN", {31'h0, iREN}, 32'h1);
    checkOutput("drop iaddr", iaddr, 32'h0000_0104);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b0, 32'h0000_0200);
      peek();
      if (!iREN) done = 1'b1;
    end
    checkOutput("drop fill done", {31'h0, done}, 32'h1);
    applyStimulus(1'b1, 32'h0000_0104);
    peek();
    checkOutput("drop later hit", {31'h0, ihit}, 32'h1);
    checkOutput("drop later data", imemload, memWord(32'h0000_0104));

    // Reset while a fill is outstanding.
    latFixed = 4;
    applyStimulus(1'b1, 32'h0000_0308);
    peek();
    applyStimulus(1'b1, 32'h0000_0308);
    peek();
    checkOutput("pre-reset iREN", {31'h0, iREN}, 32'h1);
    applyStimulus(1'b1, 32'h0000_0308);
    nRST = 1'b0;
    #1;
    checkOutput("async rst iREN", {31'h0, iREN}, 32'h0);
    checkOutput("async rst iaddr", iaddr, 32'h0);
    checkOutput("async rst ihit", {31'h0, ihit}, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    latFixed = 1;
    applyStimulus(1'b1, 32'h0000_0040);
    peek();
    checkOutput("post-rst 0x40 miss", {31'h0, ihit}, 32'h0);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b1, 32'h0000_0040);
      peek();
      if (ihit) done = 1'b1;
    end
    checkOutput("post-rst refill", {31'h0, done}, 32'h1);

    // Randomized traffic over a small address pool with occasional resets.
    latFixed = -1;
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      a = ({30'h0, 2'($urandom_range(0, 3))} << 6)
        | ({28'h0, 4'($urandom_range(0, 15))} << 2)
        | {30'h0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      applyStimulus($urandom_range(0, 3) != 0, a);
      nRST = ($urandom_range(0, 149) != 0);
    end
    applyStimulus(1'b0, 32'h0);
    nRST = 1'b1;
    repeat (8) @(posedge CLK);
    peek();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
